// File: rtl/fifo_pkg.sv
// Shared types and constants for the parametrised synchronous FIFO.
// The pointer-width helper gives the extra wrap bit used to tell full from empty.
package fifo_pkg;

  typedef enum logic {
    FIFO_STD  = 1'b0,
    FIFO_FWFT = 1'b1
  } fifo_mode_e;

  localparam int DEF_WIDTH = 8;
  localparam int DEF_DEPTH = 8;

  function automatic int ptr_width(input int depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/fifo_mem_2p.sv
// Two-port storage array: one synchronous write port, one asynchronous read port.
// Deliberately has no reset so it maps onto plain RAM/regfile cells.
module fifo_mem_2p #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8,
  localparam int AW   = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             i_we,
  input  logic [AW-1:0]    i_waddr,
  input  logic [WIDTH-1:0] i_wdata,
  input  logic [AW-1:0]    i_raddr,
  output logic [WIDTH-1:0] o_rdata
);

  logic [WIDTH-1:0] r_mem [DEPTH];

  always_ff @(posedge clk) begin
    if (i_we) r_mem[i_waddr] <= i_wdata;
  end

  assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/fifo_sync_param.sv
// Parametrised single-clock FIFO with occupancy count, threshold flags, error pulses
// and a choice of registered or first-word-fall-through read data.
module fifo_sync_param
  import fifo_pkg::*;
#(
  parameter int WIDTH     = DEF_WIDTH,
  parameter int DEPTH     = DEF_DEPTH,
  parameter int AF_THRESH = 6,
  parameter int AE_THRESH = 2,
  parameter int FWFT      = 0,
  localparam int PW       = ptr_width(DEPTH),
  localparam int AW       = PW - 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             wr_en,
  input  logic [WIDTH-1:0] D_in,
  input  logic             rd_en,
  output logic [WIDTH-1:0] D_out,
  output logic             full,
  output logic             empty,
  output logic             almost_full,
  output logic             almost_empty,
  output logic [AW:0]      count,
  output logic             overflow,
  output logic             underflow,
  output logic [AW-1:0]    wptr,
  output logic [AW-1:0]    rptr
);

  localparam fifo_mode_e MODE = (FWFT != 0) ? FIFO_FWFT : FIFO_STD;

  logic [AW:0]      r_wptr, r_rptr, r_count;
  logic             r_full, r_empty, r_afull, r_aempty, r_ovf, r_unf;
  logic             w_wr_acc, w_rd_acc;
  logic [AW:0]      w_count_nxt;
  logic [WIDTH-1:0] w_rdata;

  // Acceptance uses the registered flags, so a write on a full FIFO is dropped
  // even when a read frees a slot on the same edge (and vice versa when empty).
  assign w_wr_acc = wr_en & ~r_full;
  assign w_rd_acc = rd_en & ~r_empty;

  always_comb begin
    w_count_nxt = r_count;
    case ({w_wr_acc, w_rd_acc})
      2'b10:   w_count_nxt = r_count + 1'b1;
      2'b01:   w_count_nxt = r_count - 1'b1;
      default: w_count_nxt = r_count;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wptr   <= '0;
      r_rptr   <= '0;
      r_count  <= '0;
      r_full   <= 1'b0;
      r_empty  <= 1'b1;
      r_afull  <= 1'b0;
      r_aempty <= 1'b1;
      r_ovf    <= 1'b0;
      r_unf    <= 1'b0;
    end else begin
      if (w_wr_acc) r_wptr <= r_wptr + 1'b1;
      if (w_rd_acc) r_rptr <= r_rptr + 1'b1;
      r_count  <= w_count_nxt;
      r_full   <= (w_count_nxt == PW'(DEPTH));
      r_empty  <= (w_count_nxt == '0);
      r_afull  <= (w_count_nxt >= PW'(AF_THRESH));
      r_aempty <= (w_count_nxt <= PW'(AE_THRESH));
      r_ovf    <= wr_en & r_full;
      r_unf    <= rd_en & r_empty;
    end
  end

  // Gating with rst keeps a write coincident with reset from landing in memory.
  fifo_mem_2p #(.WIDTH(WIDTH), .DEPTH(DEPTH)) u_mem (
    .clk     (clk),
    .i_we    (w_wr_acc & ~rst),
    .i_waddr (r_wptr[AW-1:0]),
    .i_wdata (D_in),
    .i_raddr (r_rptr[AW-1:0]),
    .o_rdata (w_rdata)
  );

  generate
    if (MODE == FIFO_FWFT) begin : g_fwft
      assign D_out = r_empty ? '0 : w_rdata;
    end else begin : g_std
      logic [WIDTH-1:0] r_dout;
      always_ff @(posedge clk or posedge rst) begin
        if (rst)           r_dout <= '0;
        else if (w_rd_acc) r_dout <= w_rdata;
      end
      assign D_out = r_dout;
    end
  endgenerate

  assign full         = r_full;
  assign empty        = r_empty;
  assign almost_full  = r_afull;
  assign almost_empty = r_aempty;
  assign count        = r_count;
  assign overflow     = r_ovf;
  assign underflow    = r_unf;
  assign wptr         = r_wptr[AW-1:0];
  assign rptr         = r_rptr[AW-1:0];

endmodule

// File: tb/tb_fifo_sync_param.sv
// Directed bench for fifo_sync_param: a standard-mode and an FWFT instance on one clock.
module tb_fifo_sync_param;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  always #5 clk = ~clk;

  // standard-read instance
  logic       wr_en = 1'b0, rd_en = 1'b0;
  logic [7:0] d_in = '0, d_out;
  logic       full, empty, afull, aempty, ovf, unf;
  logic [3:0] count;
  logic [2:0] wptr, rptr;

  // FWFT instance
  logic       f_wr = 1'b0, f_rd = 1'b0;
  logic [7:0] f_din = '0, f_dout;
  logic       f_full, f_empty, f_afull, f_aempty, f_ovf, f_unf;
  logic [3:0] f_count;
  logic [2:0] f_wptr, f_rptr;

  int n_chk = 0;
  int n_err = 0;

  fifo_sync_param #(.WIDTH(8), .DEPTH(8), .AF_THRESH(6), .AE_THRESH(2), .FWFT(0)) dut (
    .clk(clk), .rst(rst), .wr_en(wr_en), .D_in(d_in), .rd_en(rd_en), .D_out(d_out),
    .full(full), .empty(empty), .almost_full(afull), .almost_empty(aempty), .count(count),
    .overflow(ovf), .underflow(unf), .wptr(wptr), .rptr(rptr)
  );

  fifo_sync_param #(.WIDTH(8), .DEPTH(8), .AF_THRESH(6), .AE_THRESH(2), .FWFT(1)) dut_f (
    .clk(clk), .rst(rst), .wr_en(f_wr), .D_in(f_din), .rd_en(f_rd), .D_out(f_dout),
    .full(f_full), .empty(f_empty), .almost_full(f_afull), .almost_empty(f_aempty),
    .count(f_count), .overflow(f_ovf), .underflow(f_unf), .wptr(f_wptr), .rptr(f_rptr)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // advance one clock edge and settle away from it
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    // ---------------- reset ----------------
    step(); step();
    rst = 1'b0;
    chk("rst_empty", empty, 1);
    chk("rst_aempty", aempty, 1);
    chk("rst_full", full, 0);
    chk("rst_afull", afull, 0);
    chk("rst_count", count, 0);
    chk("rst_dout", d_out, 8'h00);
    chk("rst_wptr", wptr, 0);
    chk("rst_rptr", rptr, 0);
    chk("rst_ovf", ovf, 0);
    chk("rst_unf", unf, 0);
    chk("rst_f_dout", f_dout, 8'h00);
    chk("rst_f_empty", f_empty, 1);

    // ---------------- 1: fill, overflow, drain ----------------
    for (int i = 0; i < 8; i++) begin
      wr_en = 1'b1; d_in = 8'h10 + 8'(i);
      step();
      chk("t1_count", count, i + 1);
      chk("t1_afull", afull, (i + 1 >= 6) ? 1 : 0);
      chk("t1_full", full, (i == 7) ? 1 : 0);
    end
    d_in = 8'h99;
    step();
    chk("t1_ovf", ovf, 1);
    chk("t1_ovf_count", count, 8);
    chk("t1_ovf_wptr", wptr, 0);
    wr_en = 1'b0;
    step();
    chk("t1_ovf_drop", ovf, 0);
    for (int i = 0; i < 8; i++) begin
      rd_en = 1'b1;
      step();
      chk("t1_rd_data", d_out, 8'h10 + i);
      chk("t1_rd_count", count, 7 - i);
    end
    rd_en = 1'b0;
    chk("t1_empty", empty, 1);
    chk("t1_aempty", aempty, 1);

    // ---------------- 2: reset mid-stream ----------------
    for (int i = 0; i < 3; i++) begin
      wr_en = 1'b1; d_in = 8'h31 + 8'(i);
      step();
    end
    wr_en = 1'b0;
    chk("t2_pre_count", count, 3);
    rst = 1'b1;
    #1;
    chk("t2_empty", empty, 1);
    chk("t2_count", count, 0);
    chk("t2_dout", d_out, 8'h00);
    chk("t2_wptr", wptr, 0);
    chk("t2_rptr", rptr, 0);
    rst = 1'b0;
    rd_en = 1'b1;
    step();
    rd_en = 1'b0;
    chk("t2_unf", unf, 1);
    chk("t2_unf_dout", d_out, 8'h00);
    chk("t2_unf_count", count, 0);
    step();
    chk("t2_unf_clear", unf, 0);

    // ---------------- 3: pointer wrap ----------------
    for (int k = 0; k <= 12; k++) begin
      wr_en = (k < 12); d_in = 8'h40 + 8'(k);
      rd_en = (k >= 1);
      step();
      if (k >= 1) chk("t3_data", d_out, 8'h40 + k - 1);
      chk("t3_count", count, (k < 12) ? 1 : 0);
      if (k == 7) begin
        chk("t3_wptr_wrap", wptr, 0);
        chk("t3_rptr_7", rptr, 7);
      end
    end
    wr_en = 1'b0; rd_en = 1'b0;
    chk("t3_wptr_end", wptr, 4);
    chk("t3_rptr_end", rptr, 4);

    // ---------------- 4: simultaneous access ----------------
    for (int i = 0; i < 4; i++) begin
      wr_en = 1'b1; d_in = 8'h50 + 8'(i);
      step();
    end
    rd_en = 1'b1; d_in = 8'h54;
    step();
    rd_en = 1'b0;
    chk("t4_both_count", count, 4);
    chk("t4_both_data", d_out, 8'h50);
    for (int i = 0; i < 4; i++) begin
      d_in = 8'h55 + 8'(i);
      step();
    end
    chk("t4_full", full, 1);
    rd_en = 1'b1; d_in = 8'hEE;
    step();
    wr_en = 1'b0;
    chk("t4_full_count", count, 7);
    chk("t4_full_ovf", ovf, 1);
    chk("t4_full_data", d_out, 8'h51);
    chk("t4_full_clear", full, 0);
    for (int i = 0; i < 7; i++) begin
      step();
      chk("t4_drain", d_out, 8'h52 + i);
    end
    chk("t4_drained", empty, 1);
    wr_en = 1'b1; d_in = 8'h60;
    step();
    wr_en = 1'b0; rd_en = 1'b0;
    chk("t4_empty_count", count, 1);
    chk("t4_empty_unf", unf, 1);
    chk("t4_hold_dout", d_out, 8'h58);
    rd_en = 1'b1;
    step();
    rd_en = 1'b0;
    chk("t4_last_data", d_out, 8'h60);
    chk("t4_last_count", count, 0);

    // ---------------- 5: thresholds ----------------
    for (int i = 1; i <= 6; i++) begin
      wr_en = 1'b1; d_in = 8'h70 + 8'(i);
      step();
      chk("t5_aempty", aempty, (i <= 2) ? 1 : 0);
      chk("t5_afull", afull, (i >= 6) ? 1 : 0);
    end
    wr_en = 1'b0; rd_en = 1'b1;
    step();
    chk("t5_pop_count", count, 5);
    chk("t5_pop_afull", afull, 0);
    for (int i = 0; i < 5; i++) step();
    rd_en = 1'b0;
    chk("t5_drained", empty, 1);
    chk("t5_last", d_out, 8'h76);

    // ---------------- 6: FWFT ----------------
    f_wr = 1'b1; f_din = 8'hA5;
    step();
    f_wr = 1'b0;
    chk("t6_head", f_dout, 8'hA5);
    chk("t6_count1", f_count, 1);
    f_wr = 1'b1; f_din = 8'h5A;
    step();
    f_wr = 1'b0;
    chk("t6_head_hold", f_dout, 8'hA5);
    chk("t6_count2", f_count, 2);
    f_rd = 1'b1;
    step();
    chk("t6_next", f_dout, 8'h5A);
    chk("t6_count_pop", f_count, 1);
    step();
    f_rd = 1'b0;
    chk("t6_empty", f_empty, 1);
    chk("t6_zero", f_dout, 8'h00);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
